nco_gen: RTL
============

NCO_GEN -- requirements
Module: nco_gen

Interface
REQ-001 SHALL have parameter W_phase, default 16, meaning phase accumulator and increment width.
REQ-002 SHALL have parameter W_out, default 8, meaning signed width of nco_cos/nco_sin (LUT amplitude 127 at default).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port phase_inc_i  input  W_phase  unsigned phase increment per enabled sample.
REQ-006 SHALL have port inc_load_i  input  1  captures phase_inc_i into the increment register.
REQ-007 SHALL have port phase_clr_i  input  1  forces accumulator to 0.
REQ-008 SHALL have port enable_i  input  1  requests one cos/sin sample this cycle.
REQ-009 SHALL have port nco_cos  output  W_out  signed cosine sample (consumer: complex_mult nco_cos).
REQ-010 SHALL have port nco_sin  output  W_out  signed sine sample (consumer: complex_mult nco_sin).
REQ-011 SHALL have port valid_o  output  1  nco_cos/nco_sin valid this cycle.

Function
REQ-012 SHALL hold a W_phase-bit accumulator acc and increment register inc; f_out = inc*f_clk/2^W_phase.
REQ-013 SHALL, on a cycle with enable_i=1, emit a sample for phase index p = acc[W_phase-1:W_phase-8] and set acc <= acc+inc (modulo 2^W_phase, silent wrap).
REQ-014 SHALL hold acc unchanged when enable_i=0.
REQ-015 SHALL give phase_clr_i priority: with clr=1 and enable_i=1 the sample uses p=0 and acc <= inc; with clr=1, enable_i=0, acc <= 0.
REQ-016 SHALL make inc_load_i take effect for the next accumulation: same-cycle enable uses the old inc; simultaneous load+clr+enable gives acc <= old inc.
REQ-017 SHALL use a 64-entry quarter-wave table LUT[k] = round(127*sin(2*pi*(k+0.5)/256)), k=0..63 (LUT[0]=2, LUT[63]=127).
REQ-018 SHALL split p into quadrant q=p[7:6], address a=p[5:0]; sin: q0 LUT[a], q1 LUT[63-a], q2 -LUT[a], q3 -LUT[63-a].
REQ-019 SHALL compute cos with the same rule applied to p+64 (mod 256).
REQ-020 SHALL never produce -128; negation of values 2..127 needs no saturation.
REQ-021 SHALL be a 3-stage pipeline: S1 register p, S2 registered LUT read plus quadrant, S3 registered sign/mirror result; valid_o = enable_i delayed exactly 3 cycles.
REQ-022 SHALL accept enable_i every cycle (throughput 1 sample/clk); gaps in enable_i appear as identical gaps in valid_o.
REQ-023 SHALL hold nco_cos/nco_sin at last value when valid_o=0.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, set acc=0, inc=0, all pipeline valids=0, nco_cos=0, nco_sin=0, valid_o=0.
REQ-025 SHALL, on reset mid-stream, discard all in-flight samples; valid_o=0 from the cycle after the reset edge; first post-reset sample uses p=0.
REQ-026 SHALL ignore enable_i, inc_load_i, phase_clr_i in any cycle where rst=1.

Structure
REQ-027 SHALL place W_phase default, LUT depth (64) and amplitude (127) constants in projectGlobalParam.v.
REQ-028 SHALL implement the table as sub-module nco_sin_lut (64x8 ROM, registered read, no reset needed on data).
REQ-029 SHALL contain no multipliers; only accumulator adder, address mirror and two's-complement negation.

Verification
REQ-030 Reset, inc=0, enable_i held 1 -> valid_o rises on 3rd cycle after first enable; nco_sin=2, nco_cos=127 constant.
REQ-031 Load inc=16384, enable continuous -> sin sequence 2,127,-2,-127 repeating; cos 127,-2,-127,2.
REQ-032 inc=0x8000 -> sin alternates 2,-2; cos alternates 127,-127; acc wraps to 0 without glitch.
REQ-033 inc=16384, enable pattern 1,0,0,1,1 -> valid_o pattern 1,0,0,1,1 delayed 3; sin 2,127,-2 (phase held across gap).
REQ-034 Mid-stream: load inc=4096 with enable same cycle, then phase_clr_i+enable -> old inc used once, clear sample sin=2/cos=127, next p=16.
REQ-035 rst asserted during continuous output -> valid_o=0, outputs 0 next cycle; after release and enable, first sample sin=2, cos=127.

Source files
------------

// File: rtl/nco_gen_pkg.sv
// nco_gen_pkg -- shared constants and types for the numerically controlled
// oscillator (nco_gen) and its quarter-wave sine table (nco_sin_lut).
//   NCO_W_PHASE : default phase accumulator / increment width
//   LUT_DEPTH   : quarter-wave table entries (64)
//   LUT_AMP     : table peak amplitude (127)
//   SIN_QTR     : LUT[k] = round(127*sin(2*pi*(k+0.5)/256)), k = 0..63
package nco_gen_pkg;

  localparam int NCO_W_PHASE = 16;
  localparam int LUT_DEPTH   = 64;
  localparam int LUT_AMP     = 127;
  localparam int LUT_AW      = 6;
  localparam int LUT_DW      = 8;
  localparam int PHASE_IDX_W = 8;

  // Half-sample offset keeps every entry in 2..127, so the mirrored and
  // negated waveform is symmetric and never reaches -128.
  localparam logic [LUT_DW-1:0] SIN_QTR [LUT_DEPTH] = '{
    8'd2,   8'd5,   8'd8,   8'd11,  8'd14,  8'd17,  8'd20,  8'd23,
    8'd26,  8'd29,  8'd32,  8'd35,  8'd38,  8'd41,  8'd44,  8'd47,
    8'd50,  8'd53,  8'd56,  8'd58,  8'd61,  8'd64,  8'd67,  8'd69,
    8'd72,  8'd74,  8'd77,  8'd79,  8'd82,  8'd84,  8'd86,  8'd89,
    8'd91,  8'd93,  8'd95,  8'd97,  8'd99,  8'd101, 8'd103, 8'd105,
    8'd106, 8'd108, 8'd110, 8'd111, 8'd113, 8'd114, 8'd115, 8'd117,
    8'd118, 8'd119, 8'd120, 8'd121, 8'd122, 8'd123, 8'd124, 8'd124,
    8'd125, 8'd125, 8'd126, 8'd126, 8'd127, 8'd127, 8'd127, LUT_DW'(LUT_AMP)
  };

  // Quadrant of the 8-bit phase index (top two bits).
  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

endpackage

// File: rtl/nco_gen_sin_lut.sv
// nco_sin_lut -- 64 x 8 quarter-wave sine ROM with a registered read.
// Ports:
//   clk    : clock
//   i_addr : table address (0..63)
//   o_data : LUT[i_addr], valid one cycle after the address is presented
// The data register carries no reset; downstream valid tracking makes its
// post-reset contents irrelevant.
module nco_sin_lut
  import nco_gen_pkg::*;
(
  input  logic              clk,
  input  logic [LUT_AW-1:0] i_addr,
  output logic [LUT_DW-1:0] o_data
);

  logic [LUT_DW-1:0] r_data;

  always_ff @(posedge clk) begin
    r_data <= SIN_QTR[i_addr];
  end

  assign o_data = r_data;

endmodule

// File: rtl/nco_gen.sv
// nco_gen -- phase-accumulator NCO producing signed cos/sin samples through a
// 3-stage pipeline (S1 phase index, S2 table read + quadrant, S3 sign/mirror).
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   phase_inc_i : unsigned phase increment, captured when inc_load_i = 1
//   inc_load_i  : load phase_inc_i into the increment register
//   phase_clr_i : clear the accumulator (wins over accumulation)
//   enable_i    : request one sample this cycle
//   nco_cos     : signed cosine sample
//   nco_sin     : signed sine sample
//   valid_o     : nco_cos/nco_sin valid; enable_i delayed by 3 cycles
// Requires W_phase >= 8 and W_out >= 8.
module nco_gen
  import nco_gen_pkg::*;
#(
  parameter int W_phase = NCO_W_PHASE,
  parameter int W_out   = LUT_DW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [W_phase-1:0]      phase_inc_i,
  input  logic                    inc_load_i,
  input  logic                    phase_clr_i,
  input  logic                    enable_i,
  output logic signed [W_out-1:0] nco_cos,
  output logic signed [W_out-1:0] nco_sin,
  output logic                    valid_o
);

  logic [W_phase-1:0]     r_acc;
  logic [W_phase-1:0]     r_inc;
  logic [PHASE_IDX_W-1:0] r_p;
  logic                   r_v1;
  logic                   r_v2;
  logic                   r_v3;
  logic [PHASE_IDX_W-1:0] w_p_cur;

  assign w_p_cur = r_acc[W_phase-1 -: PHASE_IDX_W];

  // Accumulator and increment. A same-cycle load only affects later
  // accumulations, so a clear+enable restarts from the increment in force
  // before this cycle's load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_inc <= '0;
    end else begin
      if (inc_load_i) begin
        r_inc <= phase_inc_i;
      end
      if (phase_clr_i) begin
        r_acc <= enable_i ? r_inc : '0;
      end else if (enable_i) begin
        r_acc <= r_acc + r_inc;
      end
    end
  end

  // S1: capture the phase index of the requested sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p  <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= enable_i;
      if (enable_i) begin
        r_p <= phase_clr_i ? '0 : w_p_cur;
      end
    end
  end

  // Valid tracking for S2 and S3.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  // Channel 0 is sine at p, channel 1 is cosine evaluated as sine at p+64.
  logic signed [W_out-1:0] w_sample [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic [PHASE_IDX_W-1:0]  w_ph;
    quad_e                   w_quad;
    logic                    w_mirror;
    logic                    w_neg;
    logic [LUT_AW-1:0]       w_addr;
    logic [LUT_DW-1:0]       w_mag;
    logic                    r_neg;
    logic signed [W_out-1:0] r_out;

    assign w_ph     = r_p + PHASE_IDX_W'(gi * LUT_DEPTH);
    assign w_quad   = quad_e'(w_ph[PHASE_IDX_W-1 -: 2]);
    assign w_mirror = (w_quad == QUAD_1) || (w_quad == QUAD_3);
    assign w_neg    = (w_quad == QUAD_2) || (w_quad == QUAD_3);
    // 63 - a is the bitwise complement of a 6-bit address.
    assign w_addr   = w_mirror ? ~w_ph[LUT_AW-1:0] : w_ph[LUT_AW-1:0];

    // S2: registered table read; the sign travels alongside it.
    nco_sin_lut u_lut (
      .clk    (clk),
      .i_addr (w_addr),
      .o_data (w_mag)
    );

    always_ff @(posedge clk) begin
      r_neg <= w_neg;
    end

    // S3: apply sign; hold the last sample while no new one arrives.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_out <= '0;
      end else if (r_v2) begin
        r_out <= r_neg ? -W_out'(w_mag) : W_out'(w_mag);
      end
    end

    assign w_sample[gi] = r_out;
  end

  assign nco_sin = w_sample[0];
  assign nco_cos = w_sample[1];
  assign valid_o = r_v3;

endmodule
